// File: rtl/text_paste_sequencer_if.sv
// ---------------------------------------------------------------------------
// text_paste_sequencer_if
//   Bundles the host download port and the CPU receive port of the text
//   paste sequencer.
//
//   Download side (host -> sequencer):
//     dl_active  host text download in progress
//     dl_wr      one-cycle byte write strobe (valid only while dl_active=1)
//     dl_addr    byte offset of dl_data within the text
//     dl_data    downloaded byte
//   CPU side:
//     cs         access strobe, each high cycle is one access
//     address    0 = RX data, 1 = status
//     dout       registered read data
//     busy       download/playback in progress
//     overflow   sticky: an out-of-range download write was dropped
//
//   Modports: slave = sequencer, master = host/CPU model.
// ---------------------------------------------------------------------------
interface text_paste_sequencer_if;
    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cs;
    logic        address;
    logic [7:0]  dout;
    logic        busy;
    logic        overflow;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, cs, address,
        output dout, busy, overflow
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, cs, address,
        input  dout, busy, overflow
    );
endinterface

// File: rtl/text_paste_sequencer.sv
// ---------------------------------------------------------------------------
// text_paste_sequencer
//   Captures a block of text downloaded by the host into a byte buffer and
//   then "types" it into a CPU-visible receive register one character at a
//   time, leaving GAP_CYCLES clocks between characters and waiting for the
//   CPU to read each one. CR LF pairs collapse to a single CR and a lone LF
//   is presented as CR.
//
//   Parameters:
//     ADDR_W      buffer address width (2^ADDR_W bytes)
//     GAP_CYCLES  clocks between presented characters (2 .. 2^20)
//
//   Ports:
//     clock_in    system clock, rising edge
//     rst         asynchronous active-high reset
//     bus         text_paste_sequencer_if.slave (download + CPU port)
//
//   Status byte: {rx_full, busy, overflow, 5'b0}.
// ---------------------------------------------------------------------------
module text_paste_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int GAP_CYCLES = 4000
) (
    input  logic                  clock_in,
    input  logic                  rst,
    text_paste_sequencer_if.slave bus
);

    localparam int              CNT_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam int              DEPTH    = 1 << ADDR_W;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_FETCH,
        ST_PRESENT,
        ST_WAIT_READ
    } state_t;

    state_t              state_reg,       state_next;
    logic [ADDR_W-1:0]   rd_ptr_reg,      rd_ptr_next;
    logic [ADDR_W-1:0]   last_addr_reg,   last_addr_next;
    logic                any_written_reg, any_written_next;
    logic                overflow_reg,    overflow_next;
    logic                rx_full_reg,     rx_full_next;
    logic [7:0]          rx_data_reg,     rx_data_next;
    logic [7:0]          prev_byte_reg,   prev_byte_next;
    logic [CNT_W-1:0]    cnt_reg,         cnt_next;
    logic [7:0]          dout_reg,        dout_next;
    logic                dl_active_prev_reg;

    // Text buffer: plain array with a registered read port so it maps to
    // block RAM. Contents are deliberately not reset.
    logic [7:0]          mem [0:DEPTH-1];
    logic [7:0]          mem_q_reg;
    logic                mem_we;
    logic                mem_re;

    logic                busy;
    logic                in_range;
    logic                abort;
    logic                do_init;
    logic                do_advance;

    assign busy     = (state_reg != ST_IDLE);
    assign in_range = ((32'(bus.dl_addr)) >> ADDR_W) == 32'd0;

    // A fresh download request while playing back throws the old text away.
    assign abort = bus.dl_active && !dl_active_prev_reg &&
                   ((state_reg == ST_GAP)     || (state_reg == ST_FETCH) ||
                    (state_reg == ST_PRESENT) || (state_reg == ST_WAIT_READ));

    assign bus.dout     = dout_reg;
    assign bus.busy     = busy;
    assign bus.overflow = overflow_reg;

    always_ff @(posedge clock_in) begin
        if (mem_we) begin
            mem[bus.dl_addr[ADDR_W-1:0]] <= bus.dl_data;
        end
        if (mem_re) begin
            mem_q_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            rd_ptr_reg         <= '0;
            last_addr_reg      <= '0;
            any_written_reg    <= 1'b0;
            overflow_reg       <= 1'b0;
            rx_full_reg        <= 1'b0;
            rx_data_reg        <= 8'h00;
            prev_byte_reg      <= 8'h00;
            cnt_reg            <= '0;
            dout_reg           <= 8'h00;
            dl_active_prev_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            rd_ptr_reg         <= rd_ptr_next;
            last_addr_reg      <= last_addr_next;
            any_written_reg    <= any_written_next;
            overflow_reg       <= overflow_next;
            rx_full_reg        <= rx_full_next;
            rx_data_reg        <= rx_data_next;
            prev_byte_reg      <= prev_byte_next;
            cnt_reg            <= cnt_next;
            dout_reg           <= dout_next;
            dl_active_prev_reg <= bus.dl_active;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rd_ptr_next      = rd_ptr_reg;
        last_addr_next   = last_addr_reg;
        any_written_next = any_written_reg;
        overflow_next    = overflow_reg;
        rx_full_next     = rx_full_reg;
        rx_data_next     = rx_data_reg;
        prev_byte_next   = prev_byte_reg;
        cnt_next         = cnt_reg;
        dout_next        = dout_reg;
        mem_we           = 1'b0;
        mem_re           = 1'b0;
        do_init          = 1'b0;
        do_advance       = 1'b0;

        // CPU port is serviced in every state. The FSM below runs after it,
        // so a character being presented in the same cycle as a data read
        // keeps rx_full set while the read still returns the old byte.
        if (bus.cs) begin
            if (!bus.address) begin
                dout_next    = rx_data_reg;
                rx_full_next = 1'b0;
            end else begin
                dout_next = {rx_full_reg, busy, overflow_reg, 5'b0};
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (bus.dl_active) begin
                    do_init = 1'b1;
                end
            end

            ST_LOAD: begin
                if (bus.dl_active) begin
                    if (bus.dl_wr) begin
                        if (in_range) begin
                            mem_we           = 1'b1;
                            last_addr_next   = bus.dl_addr[ADDR_W-1:0];
                            any_written_next = 1'b1;
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                end else if (any_written_reg) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            // Counter runs GAP_LOAD..0, so GAP lasts exactly GAP_CYCLES clocks.
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_FETCH;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            ST_FETCH: begin
                mem_re     = 1'b1;
                state_next = ST_PRESENT;
            end

            ST_PRESENT: begin
                prev_byte_next = mem_q_reg;
                if ((mem_q_reg == CHAR_LF) && (prev_byte_reg == CHAR_CR)) begin
                    do_advance = 1'b1;
                end else begin
                    rx_data_next = (mem_q_reg == CHAR_LF) ? CHAR_CR : mem_q_reg;
                    rx_full_next = 1'b1;
                    state_next   = ST_WAIT_READ;
                end
            end

            ST_WAIT_READ: begin
                if (!rx_full_reg) begin
                    do_advance = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // last_addr is the offset of the final write, so playback stops
        // there even if the host wrote higher offsets earlier.
        if (do_advance) begin
            if (rd_ptr_reg == last_addr_reg) begin
                state_next = ST_IDLE;
            end else begin
                rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
                state_next  = ST_GAP;
                cnt_next    = GAP_LOAD;
            end
        end

        if (abort) begin
            do_init = 1'b1;
        end

        if (do_init) begin
            state_next       = ST_LOAD;
            rd_ptr_next      = '0;
            last_addr_next   = '0;
            any_written_next = 1'b0;
            overflow_next    = 1'b0;
            rx_full_next     = 1'b0;
            prev_byte_next   = 8'h00;
        end
    end

endmodule
